// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types and function-select constants for the pipelined ALU.
// Holds the per-beat operation record carried through stage 1.
// Named select codes are used by the core for the common operations.
package alu_pipe_pkg;

   // Operation fields captured with each input beat.
   typedef struct packed {
      logic [3:0] s;        // function select
      logic       m;        // 1 = logic, 0 = arithmetic
      logic       cin;      // carry-in (+1), arithmetic only
      logic       use_acc;  // substitute accumulator for operand A
      logic       acc_wr;   // write result into the accumulator
   } alu_op_t;

   localparam logic [3:0] S_ADD   = 4'd9;   // arithmetic A + B (+cin)
   localparam logic [3:0] S_SUB   = 4'd6;   // arithmetic A - B when cin = 1
   localparam logic [3:0] S_PASSA = 4'd15;  // logic pass-through of A
   localparam logic [3:0] S_ZERO  = 4'd3;   // logic constant zero

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational W-bit 74181-style function unit with flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
//
// Ports:
//   a_i, b_i   W-bit operands (A already accumulator-substituted by the caller)
//   s_i, m_i   function select and mode (m_i = 1 logic, 0 arithmetic)
//   cin_i      carry-in, ignored in logic mode
//   f_o        result; cout_o / ovf_o forced to 0 in logic mode
//   zero_o     f_o == 0;  eq_o  a_i == b_i
module alu_pipe_core
   import alu_pipe_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [3:0]   s_i,
   input  logic         m_i,
   input  logic         cin_i,
   output logic [W-1:0] f_o,
   output logic         cout_o,
   output logic         zero_o,
   output logic         eq_o,
   output logic         ovf_o
);

   logic [W-1:0] ones;
   logic [W-1:0] logic_f;
   logic [W-1:0] x_op;
   logic [W-1:0] y_op;
   logic [W:0]   sum;
   logic         arith_ovf;

   assign ones = '1;

   // Logic-mode function table.
   always_comb begin
      logic_f = '0;
      case (s_i)
         4'd0:    logic_f = ~a_i;
         4'd1:    logic_f = ~(a_i | b_i);
         4'd2:    logic_f = ~a_i & b_i;
         S_ZERO:  logic_f = '0;
         4'd4:    logic_f = ~(a_i & b_i);
         4'd5:    logic_f = ~b_i;
         4'd6:    logic_f = a_i ^ b_i;
         4'd7:    logic_f = a_i & ~b_i;
         4'd8:    logic_f = ~a_i | b_i;
         4'd9:    logic_f = ~(a_i ^ b_i);
         4'd10:   logic_f = b_i;
         4'd11:   logic_f = a_i & b_i;
         4'd12:   logic_f = ones;
         4'd13:   logic_f = a_i | ~b_i;
         4'd14:   logic_f = a_i | b_i;
         S_PASSA: logic_f = a_i;
         default: logic_f = '0;
      endcase
   end

   // Arithmetic mode adds two selected terms X + Y + cin.
   always_comb begin
      x_op = a_i;
      y_op = '0;
      case (s_i)
         4'd0:    begin x_op = a_i;         y_op = '0;          end
         4'd1:    begin x_op = a_i | b_i;   y_op = '0;          end
         4'd2:    begin x_op = a_i | ~b_i;  y_op = '0;          end
         4'd3:    begin x_op = '0;          y_op = ones;        end
         4'd4:    begin x_op = a_i;         y_op = a_i & ~b_i;  end
         4'd5:    begin x_op = a_i | b_i;   y_op = a_i & ~b_i;  end
         S_SUB:   begin x_op = a_i;         y_op = ~b_i;        end
         4'd7:    begin x_op = a_i & ~b_i;  y_op = ones;        end
         4'd8:    begin x_op = a_i;         y_op = a_i & b_i;   end
         S_ADD:   begin x_op = a_i;         y_op = b_i;         end
         4'd10:   begin x_op = a_i | ~b_i;  y_op = a_i & b_i;   end
         4'd11:   begin x_op = a_i & b_i;   y_op = ones;        end
         4'd12:   begin x_op = a_i;         y_op = a_i;         end
         4'd13:   begin x_op = a_i | b_i;   y_op = a_i;         end
         4'd14:   begin x_op = a_i | ~b_i;  y_op = a_i;         end
         4'd15:   begin x_op = a_i;         y_op = ones;        end
         default: begin x_op = a_i;         y_op = '0;          end
      endcase
   end

   assign sum = {1'b0, x_op} + {1'b0, y_op} + {{W{1'b0}}, cin_i};

   // Signed overflow: like-signed addends producing a result of the other sign.
   assign arith_ovf = (x_op[W-1] == y_op[W-1]) && (sum[W-1] != x_op[W-1]);

   assign f_o    = m_i ? logic_f : sum[W-1:0];
   assign cout_o = !m_i && sum[W];
   assign ovf_o  = !m_i && arith_ovf;
   assign zero_o = (f_o == '0);
   assign eq_o   = (a_i == b_i);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with flags and optional accumulator.
// Latency: 2 cycles from input handshake to out_valid; 1 beat/cycle throughput.
// Backpressure: holds 2 beats; in_ready = !s1 | !s2 | out_ready (depends on out_ready only).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready                input handshake
//   in_a, in_b, in_s, in_m, in_cin   operands, select, mode, carry-in
//   in_use_acc, in_acc_wr            accumulator substitute / write-back controls
//   out_valid/out_ready              output handshake
//   out_f, out_cout, out_zero,
//   out_eq, out_ovf                  registered result and flags
//
// Build option: define ALU_PIPE_ACC_EN to build the accumulator. Without it the
// accumulator controls are accepted but ignored and A is always in_a.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int           W        = 4,
   parameter logic [W-1:0] ACC_INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [3:0]   in_s,
   input  logic         in_m,
   input  logic         in_cin,
   input  logic         in_use_acc,
   input  logic         in_acc_wr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_f,
   output logic         out_cout,
   output logic         out_zero,
   output logic         out_eq,
   output logic         out_ovf
);

   // Stage 1: captured operand beat.
   logic         s1_vld_q, s1_vld_d;
   logic [W-1:0] s1_a_q;
   logic [W-1:0] s1_b_q;
   alu_op_t      s1_op_q;

   // Stage 2: registered result and flags.
   logic         s2_vld_q, s2_vld_d;
   logic [W-1:0] f_q;
   logic         cout_q, zero_q, eq_q, ovf_q;

   logic         in_hs;
   logic         s2_load;
   logic [W-1:0] a_use;

   logic [W-1:0] core_f;
   logic         core_cout, core_zero, core_eq, core_ovf;

   assign in_ready = !s1_vld_q || !s2_vld_q || out_ready;
   assign in_hs    = in_valid && in_ready;
   assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);

   // A new beat refills S1 even while its old contents move to S2.
   always_comb begin
      s1_vld_d = s1_vld_q;
      if (in_hs)
         s1_vld_d = 1'b1;
      else if (s2_load)
         s1_vld_d = 1'b0;
   end

   // A fresh result replaces a consumed one with no bubble.
   always_comb begin
      s2_vld_d = s2_vld_q;
      if (s2_load)
         s2_vld_d = 1'b1;
      else if (out_ready)
         s2_vld_d = 1'b0;
   end

`ifdef ALU_PIPE_ACC_EN
   logic [W-1:0] acc_q, acc_d;

   // The accumulator is read and written at the S1->S2 transfer, so the next
   // beat sitting in S1 sees the updated value without a stall.
   always_comb begin
      acc_d = acc_q;
      if (s2_load && s1_op_q.acc_wr)
         acc_d = core_f;
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc_q <= ACC_INIT;
      else
         acc_q <= acc_d;
   end

   assign a_use = s1_op_q.use_acc ? acc_q : s1_a_q;
`else
   logic unused_acc_ctl;

   assign unused_acc_ctl = ^{s1_op_q.use_acc, s1_op_q.acc_wr, ACC_INIT};
   assign a_use          = s1_a_q;
`endif

   alu_pipe_core #(
      .W (W)
   ) u_core (
      .a_i    (a_use),
      .b_i    (s1_b_q),
      .s_i    (s1_op_q.s),
      .m_i    (s1_op_q.m),
      .cin_i  (s1_op_q.cin),
      .f_o    (core_f),
      .cout_o (core_cout),
      .zero_o (core_zero),
      .eq_o   (core_eq),
      .ovf_o  (core_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_op_q  <= '0;
         s2_vld_q <= 1'b0;
         f_q      <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         eq_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         if (in_hs) begin
            s1_a_q  <= in_a;
            s1_b_q  <= in_b;
            s1_op_q <= '{s: in_s, m: in_m, cin: in_cin,
                         use_acc: in_use_acc, acc_wr: in_acc_wr};
         end
         if (s2_load) begin
            f_q    <= core_f;
            cout_q <= core_cout;
            zero_q <= core_zero;
            eq_q   <= core_eq;
            ovf_q  <= core_ovf;
         end
      end
   end

   assign out_valid = s2_vld_q;
   assign out_f     = f_q;
   assign out_cout  = cout_q;
   assign out_zero  = zero_q;
   assign out_eq    = eq_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand-written pipeline sequences for alu_pipe.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed for W = 4.
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   localparam int         W        = 4;
   localparam logic [3:0] ACC_INIT = 4'hA;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] in_a, in_b;
   logic [3:0]   in_s;
   logic         in_m, in_cin, in_use_acc, in_acc_wr;
   logic         out_valid, out_ready;
   logic [W-1:0] out_f;
   logic         out_cout, out_zero, out_eq, out_ovf;

   always #5 clk = ~clk;

   alu_pipe #(.W(W), .ACC_INIT(ACC_INIT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
      .in_use_acc(in_use_acc), .in_acc_wr(in_acc_wr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_cout(out_cout), .out_zero(out_zero),
      .out_eq(out_eq), .out_ovf(out_ovf)
   );

   typedef struct {
      logic [3:0] a, b, s;
      logic       m, cin;
      logic [3:0] f;
      logic       cout, zero, eq, ovf;
   } vec_t;

   vec_t vecs[14];

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [3:0] rx_q[$];

   // Record every output handshake; values are stable at the falling edge.
   always @(negedge clk)
      if (!rst && out_valid && out_ready) rx_q.push_back(out_f);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
   task automatic send_beat(input logic [3:0] a, b, s, input logic m, cin, use_acc, acc_wr);
      bit ok = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_s = s; in_m = m; in_cin = cin;
      in_use_acc = use_acc; in_acc_wr = acc_wr;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (ok) @(posedge clk);
      #1 in_valid = 1'b0;
      if (!ok) begin
         total_cnt++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
   endtask

   task automatic wait_rx(input int n);
      int i = 0;
      while (rx_q.size() < n && i < 100) begin @(negedge clk); i++; end
      if (rx_q.size() < n) begin
         total_cnt++;
         $display("FAIL rx_timeout: got %0d results, required %0d", rx_q.size(), n);
      end
   endtask

   function automatic logic [3:0] rx_at(input int i);
      logic [3:0] v = 'x;
      if (i < rx_q.size()) v = rx_q[i];
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [3:0] exp_v;

      //            a      b      s      m     cin   f      cout  zero  eq    ovf
      vecs[0]  = '{4'hA, 4'h6, 4'd6,  1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'hF, 4'h1, 4'd9,  1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{4'h7, 4'h1, 4'd9,  1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{4'h5, 4'h5, 4'd6,  1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{4'h9, 4'h2, 4'd3,  1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{4'h3, 4'h3, 4'd12, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{4'h5, 4'h2, 4'd3,  1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{4'h4, 4'h9, 4'd15, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{4'h6, 4'h0, 4'd12, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{4'h5, 4'h2, 4'd1,  1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{4'h8, 4'h8, 4'd9,  1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{4'hC, 4'hA, 4'd11, 1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{4'h1, 4'h6, 4'd2,  1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{4'h3, 4'h6, 4'd10, 1'b0, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0;
      in_cin = 1'b0; in_use_acc = 1'b0; in_acc_wr = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_f", out_f, 0);
      chk("rst_flags", {out_cout, out_zero, out_eq, out_ovf}, 0);
      @(posedge clk); #1;

      // Single-beat function vectors with latency check.
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         send_beat(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, 1'b0, 1'b0);
         lat = 0;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
         end
         chk($sformatf("v%0d_latency", i), lat, 2);
         chk($sformatf("v%0d_f", i), out_f, vecs[i].f);
         chk($sformatf("v%0d_cout", i), out_cout, vecs[i].cout);
         chk($sformatf("v%0d_zero", i), out_zero, vecs[i].zero);
         chk($sformatf("v%0d_eq", i), out_eq, vecs[i].eq);
         chk($sformatf("v%0d_ovf", i), out_ovf, vecs[i].ovf);
         @(posedge clk); #1;
      end

      // Backpressure: fill both stages with out_ready low, then drain.
      out_ready = 1'b0;
      rx_q.delete();
      send_beat(4'd1, 4'd0, S_PASSA, 1'b1, 1'b0, 1'b0, 1'b0);
      send_beat(4'd2, 4'd0, S_PASSA, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_in_ready_full", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_f_head", out_f, 1);
      repeat (2) @(negedge clk);
      chk("bp_out_f_stable", out_f, 1);
      chk("bp_out_valid_stable", out_valid, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_beat(4'd3, 4'd0, S_PASSA, 1'b1, 1'b0, 1'b0, 1'b0);
      send_beat(4'd4, 4'd0, S_PASSA, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_rx(4);
      repeat (4) @(negedge clk);
      chk("bp_count", rx_q.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("bp_order%0d", i), rx_at(i), i + 1);
      @(posedge clk); #1;

      // Accumulator chaining on back-to-back beats.
      rx_q.delete();
      send_beat(4'd3, 4'd4, S_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
      send_beat(4'd5, 4'd1, S_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_rx(2);
      chk("acc_beat1", rx_at(0), 7);
`ifdef ALU_PIPE_ACC_EN
      exp_v = 4'd8;
`else
      exp_v = 4'd6;
`endif
      chk("acc_beat2", rx_at(1), exp_v);
      @(posedge clk); #1;

      // Reset mid-stream with both stages full; accumulator holds 9 beforehand.
      rx_q.delete();
      send_beat(4'd9, 4'd0, S_PASSA, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_rx(1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_beat(4'd1, 4'd0, S_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      send_beat(4'd2, 4'd0, S_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("mrst_full_before", in_ready, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_in_ready", in_ready, 1);
      chk("mrst_out_f", out_f, 0);
      rx_q.delete();
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_beat(4'd5, 4'd0, S_PASSA, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_rx(1);
      repeat (3) @(negedge clk);
`ifdef ALU_PIPE_ACC_EN
      exp_v = ACC_INIT;
`else
      exp_v = 4'd5;
`endif
      chk("mrst_acc_value", rx_at(0), exp_v);
      chk("mrst_no_stale", rx_q.size(), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 4-bit 74181-class combinational ALU. Computes all 16 logic and 16 arithmetic functions on W-bit operands. Uses a two-stage valid/ready pipeline with full throughput and backpressure, and produces carry, zero, equality and signed-overflow flags. An optional accumulator lets back-to-back operations chain without software round-trips. Sits between the operand-issue unit and the writeback/flag logic.

## Interface
- W, 4, operand/result width (≥2)
- ACC_INIT, 0, accumulator reset value (W bits)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_s  in  4  function select S[3:0]
- in_m  in  1  1 = logic, 0 = arithmetic
- in_cin  in  1  carry-in, active-high (+1)
- in_use_acc  in  1  replace A with accumulator
- in_acc_wr  in  1  write result to accumulator
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_f  out  W  result
- out_cout  out  1  carry out (arithmetic only, else 0)
- out_zero  out  1  out_f == 0
- out_eq  out  1  A == B (operands actually used)
- out_ovf  out  1  signed overflow (arithmetic only, else 0)

## Operation
- Logic (M=1), S=0..15: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A.
- Arithmetic (M=0): F = X + Y + cin, computed in W+1 bits. cout = bit W.
- (X, Y) per S=0..15:
  - (A,0), (A|B,0), (A|~B,0), (0,1s)
  - (A,A&~B), (A|B,A&~B), (A,~B), (A&~B,1s)
  - (A,A&B), (A,B), (A|~B,A&B), (A&B,1s)
  - (A,A), (A|B,A), (A|~B,A), (A,1s)
- ovf = (X[W-1]==Y[W-1]) & (F[W-1]!=X[W-1]). Logic mode forces cout = ovf = 0; cin is ignored.
- Stage 1 (S1) registers the operand beat on input handshake. Stage 2 (S2) computes combinationally from S1 and registers the result and flags on the S1→S2 transfer.
- Advance conditions:
  - S2 loads when S1 valid and (!S2 valid or out_ready).
  - S1 loads when in handshake occurs.
  - in_ready = !s1_valid | !s2_valid | out_ready.
- Beats are never dropped or reordered. Holding out_ready low keeps out_* stable.
- Accumulator: the A substitution reads acc at S1→S2 transfer. acc ← F at that same edge when acc_wr is set. A following beat therefore sees the updated acc with no stall.
- Reset (any cycle, mid-stream included): both valids → 0, acc → ACC_INIT, out_f/flags → 0. in_ready = 1 in the first post-reset cycle.

## Timing
- Latency: in handshake at edge t → out_valid at edge t+2 (no backpressure).
- Throughput: 1 beat/cycle when out_ready is held high.
- Backpressure: the pipeline holds 2 beats. in_ready drops in the cycle where both stages are full and out_ready=0.
- in_ready depends combinationally on out_ready only, never on in_valid or data.
- Simultaneous out handshake and S1→S2 transfer in the same cycle: the new result replaces the old one with no bubble.

## Configuration
- ALU_PIPE_ACC_EN defined: accumulator register and the in_use_acc/in_acc_wr behaviour are present.
- Not defined: the acc register is not built, in_use_acc and in_acc_wr are ignored (ports remain), and A is always in_a.

## Structure
- Package alu_pipe_pkg holds:
  - typedef alu_op_t {s[3:0], m, cin, use_acc, acc_wr}
  - localparams S_ADD=9, S_SUB=6 (with cin=1), S_PASSA=15 (logic), S_ZERO=3 (logic)
- Sub-module alu_pipe_core: purely combinational W-bit function/flag unit used by S2. The pipeline, handshake and accumulator live in alu_pipe.

## Test plan
All scenarios use W=4.
- Logic: M=1 S=6 A=0xA B=0x6 → out_f=0xC, cout=0, ovf=0, out_valid exactly 2 cycles after handshake.
- Add wrap: M=0 S=9 cin=0 A=0xF B=0x1 → F=0x0, cout=1, zero=1, ovf=0. Then A=0x7 B=0x1 → F=0x8, ovf=1.
- Subtract/equal: M=0 S=6 cin=1 A=0x5 B=0x5 → F=0x0, cout=1, eq=1, zero=1.
- Backpressure:
  - Stimulus: 4 beats back-to-back with A=1..4, S=15 M=1, and out_ready=0 for cycles 0–4.
  - Response: in_ready=0 after 2 beats are accepted; outputs 1,2,3,4 appear in order with no loss or duplication once out_ready=1.
- Accumulator (macro on):
  - Beat 1: A=3 B=4 S=9 acc_wr=1 → F=7.
  - Beat 2 (next cycle): use_acc=1 B=1 S=9 → F=8.
  - With the macro off, beat 2 gives F=in_a+1.
- Reset mid-stream: rst with both stages full → next cycle out_valid=0, in_ready=1, and acc equals ACC_INIT (verify via use_acc, S=15 M=1).
